// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide controller: EX op codes, FSM states
// and the default multiplier pipeline depth.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } md_state_e;

    localparam int MD_MUL_LAT = 6;
    localparam int MD_CNT_W   = $clog2(MD_MUL_LAT + 1);

endpackage

// File: rtl/muldiv_if.sv
// Connection bundle between the controller and the external mult/div IPs.
interface muldiv_if;
    logic        mul_ce;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        div_start;
    logic        div_abort;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;

    modport master (
        output mul_ce, mul_signed, mul_a, mul_b,
        input  mul_p,
        output div_start, div_abort, div_signed, div_a, div_b,
        input  div_done, div_q, div_r
    );

    modport slave (
        input  mul_ce, mul_signed, mul_a, mul_b,
        output mul_p,
        input  div_start, div_abort, div_signed, div_a, div_b,
        output div_done, div_q, div_r
    );
endinterface

// File: rtl/muldiv_hilo.sv
// Architectural HI/LO register pair; the 64-bit port (unit results) has
// priority over the 32-bit MTHI/MTLO port.
module muldiv_hilo (
    input  logic        clk,
    input  logic        rst,
    input  logic        we64,
    input  logic [63:0] wdata64,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata32,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // HI/LO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (we64) begin
            hi <= wdata64[63:32];
            lo <= wdata64[31:0];
        end else begin
            if (hi_we) hi <= wdata32;
            if (lo_we) lo <= wdata32;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage multiply/divide sequencer: issues to the external units,
// stalls the pipeline until HI/LO are written, aborts on flush.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic        stall_o,
    muldiv_if.master    md,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

    md_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             accept_mul_s, accept_div_s;
    logic             mul_ce_s, div_start_s, div_abort_s;
    logic             we64_s, hi_we_s, lo_we_s;
    logic [63:0]      wdata64_s;
    logic             mul_signed_r, div_signed_r;
    logic [31:0]      mul_a_r, mul_b_r, div_a_r, div_b_r;

    // State and cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state, unit controls and HI/LO write requests; flush overrides everything
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        stall_o      = 1'b0;
        accept_mul_s = 1'b0;
        accept_div_s = 1'b0;
        mul_ce_s     = 1'b0;
        div_start_s  = 1'b0;
        div_abort_s  = 1'b0;
        we64_s       = 1'b0;
        wdata64_s    = 64'd0;
        hi_we_s      = 1'b0;
        lo_we_s      = 1'b0;
        if (flush) begin
            state_s     = IDLE;
            cnt_s       = '0;
            div_abort_s = (state_r == DIV_BUSY);
        end else begin
            case (state_r)
                IDLE: begin
                    if (op_valid) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                stall_o      = 1'b1;
                                accept_mul_s = 1'b1;
                                cnt_s        = '0;
                                state_s      = MUL_BUSY;
                            end
                            MD_DIV, MD_DIVU: begin
                                stall_o = 1'b1;
                                if (opdata2_i != 32'd0) begin
                                    accept_div_s = 1'b1;
                                    cnt_s        = '0;
                                    state_s      = DIV_BUSY;
                                end else begin
                                    state_s = DONE;
                                end
                            end
                            MD_MTHI: hi_we_s = 1'b1;
                            MD_MTLO: lo_we_s = 1'b1;
                            default: begin
                                state_s = IDLE;
                            end
                        endcase
                    end else begin
                        state_s = IDLE;
                    end
                end
                MUL_BUSY: begin
                    stall_o  = 1'b1;
                    mul_ce_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        we64_s    = 1'b1;
                        wdata64_s = md.mul_p;
                        cnt_s     = '0;
                        state_s   = DONE;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                DIV_BUSY: begin
                    // cnt marks whether the start pulse has already been sent
                    stall_o     = 1'b1;
                    div_start_s = (cnt_r == '0);
                    cnt_s       = CNT_W'(1);
                    if (md.div_done) begin
                        we64_s    = 1'b1;
                        wdata64_s = {md.div_r, md.div_q};
                        cnt_s     = '0;
                        state_s   = DONE;
                    end else begin
                        state_s = DIV_BUSY;
                    end
                end
                DONE: state_s = IDLE;
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // Operand latches, loaded only when an op is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_r      <= 32'd0;
            mul_b_r      <= 32'd0;
            mul_signed_r <= 1'b0;
            div_a_r      <= 32'd0;
            div_b_r      <= 32'd0;
            div_signed_r <= 1'b0;
        end else if (accept_mul_s) begin
            mul_a_r      <= opdata1_i;
            mul_b_r      <= opdata2_i;
            mul_signed_r <= (op == MD_MULT);
        end else if (accept_div_s) begin
            div_a_r      <= opdata1_i;
            div_b_r      <= opdata2_i;
            div_signed_r <= (op == MD_DIV);
        end
    end

    assign md.mul_ce     = mul_ce_s;
    assign md.mul_signed = mul_signed_r;
    assign md.mul_a      = mul_a_r;
    assign md.mul_b      = mul_b_r;
    assign md.div_start  = div_start_s;
    assign md.div_abort  = div_abort_s;
    assign md.div_signed = div_signed_r;
    assign md.div_a      = div_a_r;
    assign md.div_b      = div_b_r;

    muldiv_hilo u_hilo (
        .clk     (clk),
        .rst     (rst),
        .we64    (we64_s),
        .wdata64 (wdata64_s),
        .hi_we   (hi_we_s),
        .lo_we   (lo_we_s),
        .wdata32 (opdata1_i),
        .hi      (hi_o),
        .lo      (lo_o)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with a CE-gated 6-stage
// multiplier stand-in and a hand-driven divider.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, op_valid;
    logic [2:0]  op;
    logic [31:0] opdata1, opdata2;
    logic        stall_o;
    logic [31:0] hi_o, lo_o;
    int          n_checks = 0;
    int          n_fail   = 0;

    muldiv_if md ();

    muldiv_ctrl #(.MUL_LAT(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .op_valid  (op_valid),
        .op        (op),
        .opdata1_i (opdata1),
        .opdata2_i (opdata2),
        .stall_o   (stall_o),
        .md        (md),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    // multiplier stand-in: product enters a 6-deep pipe that advances only with CE
    logic [63:0] ext_a, ext_b;
    logic [63:0] pipe [0:5];
    assign ext_a = md.mul_signed ? {{32{md.mul_a[31]}}, md.mul_a} : {32'd0, md.mul_a};
    assign ext_b = md.mul_signed ? {{32{md.mul_b[31]}}, md.mul_b} : {32'd0, md.mul_b};
    assign md.mul_p = pipe[5];
    always @(posedge clk) begin
        if (md.mul_ce) begin
            pipe[0] <= ext_a * ext_b;
            for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op and run until stall_o drops; collect per-cycle statistics.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int done_cyc, input logic [31:0] q, input logic [31:0] r,
                          input int flush_cyc, input logic exp_sign,
                          output int stall_n, output int ce_n, output int start_n,
                          output int abort_n, output int sign_err);
        int i;
        stall_n = 0; ce_n = 0; start_n = 0; abort_n = 0; sign_err = 0;
        @(posedge clk); #1;
        op_valid = 1'b1; op = o; opdata1 = a; opdata2 = b;
        flush = (flush_cyc == 0);
        i = 0;
        while (1) begin
            @(negedge clk);
            if (stall_o) stall_n++;
            if (md.mul_ce) ce_n++;
            if (md.div_start) start_n++;
            if (md.div_abort) abort_n++;
            if (md.mul_ce && (md.mul_signed != exp_sign)) sign_err++;
            if (!stall_o) break;
            if (i >= 200) begin
                check("op_timeout", 64'(i), 64'd0);
                break;
            end
            @(posedge clk); #1;
            i++;
            md.div_done = (i == done_cyc);
            md.div_q    = q;
            md.div_r    = r;
            flush       = (i == flush_cyc);
        end
        @(posedge clk); #1;
        op_valid = 1'b0; op = MD_NONE; flush = 1'b0; md.div_done = 1'b0;
        @(negedge clk);
    endtask

    int sn, cn, stn, an, se;

    initial begin
        rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = MD_NONE;
        opdata1 = 32'd0; opdata2 = 32'd0;
        md.div_done = 1'b0; md.div_q = 32'd0; md.div_r = 32'd0;
        for (int i = 0; i < 6; i++) pipe[i] = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_ce", 64'({md.mul_ce, md.div_start, md.div_abort}), 64'd0);
        check("rst_ops", {md.mul_a, md.div_b}, 64'd0);

        // MULT -3 x 5
        run_op(MD_MULT, 32'hFFFFFFFD, 32'd5, -1, 32'd0, 32'd0, -1, 1'b1, sn, cn, stn, an, se);
        check("mult_stall", 64'(sn), 64'd8);
        check("mult_ce", 64'(cn), 64'd7);
        check("mult_sign", 64'(se), 64'd0);
        check("mult_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
        check("mult_ops", {md.mul_a, md.mul_b}, 64'hFFFFFFFD_00000005);

        // MULTU FFFFFFFF x 2
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, -1, 32'd0, 32'd0, -1, 1'b0, sn, cn, stn, an, se);
        check("multu_stall", 64'(sn), 64'd8);
        check("multu_sign", 64'(se), 64'd0);
        check("multu_hilo", {hi_o, lo_o}, 64'h00000001_FFFFFFFE);

        // DIV -7 / 2, done 20 cycles after start
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 21, 32'hFFFFFFFD, 32'hFFFFFFFF, -1, 1'b0, sn, cn, stn, an, se);
        check("div_stall", 64'(sn), 64'd22);
        check("div_start", 64'(stn), 64'd1);
        check("div_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
        check("div_ops", {md.div_a, md.div_b}, 64'hFFFFFFF9_00000002);
        check("div_signed", 64'(md.div_signed), 64'd1);

        // DIVU by zero
        run_op(MD_DIVU, 32'd77, 32'd0, -1, 32'd0, 32'd0, -1, 1'b0, sn, cn, stn, an, se);
        check("div0_stall", 64'(sn), 64'd1);
        check("div0_start", 64'(stn), 64'd0);
        check("div0_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
        check("div0_ops", 64'(md.div_a), 64'hFFFFFFF9);

        // flush on the mult completion cycle
        run_op(MD_MULT, 32'd7, 32'd9, -1, 32'd0, 32'd0, 7, 1'b1, sn, cn, stn, an, se);
        check("mflush_stall", 64'(sn), 64'd7);
        check("mflush_ce", 64'(cn), 64'd6);
        check("mflush_abort", 64'(an), 64'd0);
        check("mflush_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);

        // flush in DIV_BUSY coinciding with div_done
        run_op(MD_DIVU, 32'd100, 32'd7, 5, 32'd14, 32'd2, 5, 1'b0, sn, cn, stn, an, se);
        check("dflush_stall", 64'(sn), 64'd5);
        check("dflush_abort", 64'(an), 64'd1);
        check("dflush_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);

        // div_done outside DIV_BUSY must not write
        @(posedge clk); #1 md.div_done = 1'b1; md.div_q = 32'h1111; md.div_r = 32'h2222;
        @(posedge clk); #1 md.div_done = 1'b0;
        @(negedge clk);
        check("stray_done", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);

        // controller returned to IDLE cleanly: a fresh MULT has the full stall
        run_op(MD_MULT, 32'd6, 32'd7, -1, 32'd0, 32'd0, -1, 1'b1, sn, cn, stn, an, se);
        check("post_flush_stall", 64'(sn), 64'd8);
        check("post_flush_hilo", {hi_o, lo_o}, 64'h00000000_0000002A);

        // MTHI then MTLO back-to-back
        @(posedge clk); #1 op_valid = 1'b1; op = MD_MTHI; opdata1 = 32'h12345678;
        @(negedge clk);
        check("mthi_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1 op = MD_MTLO; opdata1 = 32'h9ABCDEF0;
        @(negedge clk);
        check("mtlo_stall", 64'(stall_o), 64'd0);
        check("mthi_hi", 64'(hi_o), 64'h12345678);
        @(posedge clk); #1 op_valid = 1'b0; op = MD_NONE;
        @(negedge clk);
        check("mtlo_hilo", {hi_o, lo_o}, 64'h12345678_9ABCDEF0);

        // reset in the middle of a multiply
        @(posedge clk); #1 op_valid = 1'b1; op = MD_MULT; opdata1 = 32'd3; opdata2 = 32'd4;
        repeat (3) @(posedge clk);
        #1 op_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("mrst_hilo", {hi_o, lo_o}, 64'd0);
        check("mrst_stall", 64'({stall_o, md.mul_ce}), 64'd0);
        check("mrst_ops", {md.mul_a, md.mul_b}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_idle", 64'(stall_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
